// File: rtl/tb_collision_scan.sv
// Tank/bullet collision scanner: snapshots bullets and tanks on Start, tests one bullet per cycle against all tanks.
// Latency: Done pulses NUM_BULLETS cycles after the Start edge; one scan per NUM_BULLETS+1 cycles.
// Backpressure: none; Start is dropped while Busy=1, results hold in IDLE until the next accepted Start.
//
// Ports: Clk/Reset_n (async active-low); Start request; packed bullet X/Y/Active/Owner and tank X/Y/Size
// inputs; registered outputs Busy, Done (1-cycle pulse), Tank_Hit, Hit_Bullet_Idx (per tank), Bullet_Hit.
module tb_collision_scan #(
   parameter int NUM_BULLETS = 12,
   parameter int NUM_TANKS   = 2,
   parameter int COORD_W     = 10,
   parameter int SELF_HIT    = 1,
   localparam int BIDX_W     = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1,
   localparam int TID_W      = (NUM_TANKS > 1) ? $clog2(NUM_TANKS) : 1
) (
   input  logic                            Clk,
   input  logic                            Reset_n,
   input  logic                            Start,
   input  logic [NUM_BULLETS*COORD_W-1:0]  Bullet_X,
   input  logic [NUM_BULLETS*COORD_W-1:0]  Bullet_Y,
   input  logic [NUM_BULLETS-1:0]          Bullet_Active,
   input  logic [NUM_BULLETS*TID_W-1:0]    Bullet_Owner,
   input  logic [NUM_TANKS*COORD_W-1:0]    Tank_X,
   input  logic [NUM_TANKS*COORD_W-1:0]    Tank_Y,
   input  logic [NUM_TANKS*COORD_W-1:0]    Tank_Size,
   output logic                            Busy,
   output logic                            Done,
   output logic [NUM_TANKS-1:0]            Tank_Hit,
   output logic [NUM_TANKS*BIDX_W-1:0]     Hit_Bullet_Idx,
   output logic [NUM_BULLETS-1:0]          Bullet_Hit
);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t                          state_q, state_d;
   logic [BIDX_W-1:0]               idx_q, idx_d;
   logic                            done_q, done_d;

   // Snapshot of the frame taken when Start is accepted
   logic [NUM_BULLETS*COORD_W-1:0]  bx_q, bx_d, by_q, by_d;
   logic [NUM_BULLETS-1:0]          ba_q, ba_d;
   logic [NUM_BULLETS*TID_W-1:0]    bo_q, bo_d;
   logic [NUM_TANKS*COORD_W-1:0]    tx_q, tx_d, ty_q, ty_d, ts_q, ts_d;

   logic [NUM_TANKS-1:0]            tank_hit_q, tank_hit_d;
   logic [NUM_TANKS*BIDX_W-1:0]     hit_idx_q, hit_idx_d;
   logic [NUM_BULLETS-1:0]          bullet_hit_q, bullet_hit_d;

   // Bullet currently under test
   logic [COORD_W-1:0]              cur_x, cur_y;
   logic                            cur_a;
   logic [TID_W-1:0]                cur_o;
   logic [NUM_TANKS-1:0]            tank_match;

   always_comb begin
      cur_x = '0;
      cur_y = '0;
      cur_a = 1'b0;
      cur_o = '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
         if (idx_q == BIDX_W'(i)) begin
            cur_x = bx_q[i*COORD_W +: COORD_W];
            cur_y = by_q[i*COORD_W +: COORD_W];
            cur_a = ba_q[i];
            cur_o = bo_q[i*TID_W +: TID_W];
         end
      end
   end

   // Bounds are one bit wider than coordinates: the low bound clamps at 0 and
   // the high bound may exceed the coordinate range without wrapping.
   for (genvar t = 0; t < NUM_TANKS; t++) begin : g_tank
      logic [COORD_W:0] tx_e, ty_e, ts_e, cx_e, cy_e;
      logic [COORD_W:0] lo_x, hi_x, lo_y, hi_y;
      logic             own_ok;

      assign tx_e = {1'b0, tx_q[t*COORD_W +: COORD_W]};
      assign ty_e = {1'b0, ty_q[t*COORD_W +: COORD_W]};
      assign ts_e = {1'b0, ts_q[t*COORD_W +: COORD_W]};
      assign cx_e = {1'b0, cur_x};
      assign cy_e = {1'b0, cur_y};
      assign lo_x = (tx_e >= ts_e) ? (tx_e - ts_e) : '0;
      assign lo_y = (ty_e >= ts_e) ? (ty_e - ts_e) : '0;
      assign hi_x = tx_e + ts_e;
      assign hi_y = ty_e + ts_e;
      // Owner IDs outside the tank range never equal t, so they are never excluded
      assign own_ok = (SELF_HIT != 0) || (cur_o != TID_W'(t));
      assign tank_match[t] = cur_a && own_ok &&
                             (cx_e >= lo_x) && (cx_e <= hi_x) &&
                             (cy_e >= lo_y) && (cy_e <= hi_y);
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      done_d       = 1'b0;
      bx_d         = bx_q;
      by_d         = by_q;
      ba_d         = ba_q;
      bo_d         = bo_q;
      tx_d         = tx_q;
      ty_d         = ty_q;
      ts_d         = ts_q;
      tank_hit_d   = tank_hit_q;
      hit_idx_d    = hit_idx_q;
      bullet_hit_d = bullet_hit_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d      = SCAN;
               idx_d        = '0;
               bx_d         = Bullet_X;
               by_d         = Bullet_Y;
               ba_d         = Bullet_Active;
               bo_d         = Bullet_Owner;
               tx_d         = Tank_X;
               ty_d         = Tank_Y;
               ts_d         = Tank_Size;
               tank_hit_d   = '0;
               hit_idx_d    = '0;
               bullet_hit_d = '0;
            end
         end
         SCAN: begin
            for (int t = 0; t < NUM_TANKS; t++) begin
               if (tank_match[t]) begin
                  tank_hit_d[t] = 1'b1;
                  // Bullets are scanned in ascending order, so the first hit is the lowest index
                  if (!tank_hit_q[t]) begin
                     hit_idx_d[t*BIDX_W +: BIDX_W] = idx_q;
                  end
               end
            end
            for (int i = 0; i < NUM_BULLETS; i++) begin
               if ((idx_q == BIDX_W'(i)) && (|tank_match)) begin
                  bullet_hit_d[i] = 1'b1;
               end
            end
            if (idx_q == BIDX_W'(NUM_BULLETS - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         done_q       <= 1'b0;
         bx_q         <= '0;
         by_q         <= '0;
         ba_q         <= '0;
         bo_q         <= '0;
         tx_q         <= '0;
         ty_q         <= '0;
         ts_q         <= '0;
         tank_hit_q   <= '0;
         hit_idx_q    <= '0;
         bullet_hit_q <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         done_q       <= done_d;
         bx_q         <= bx_d;
         by_q         <= by_d;
         ba_q         <= ba_d;
         bo_q         <= bo_d;
         tx_q         <= tx_d;
         ty_q         <= ty_d;
         ts_q         <= ts_d;
         tank_hit_q   <= tank_hit_d;
         hit_idx_q    <= hit_idx_d;
         bullet_hit_q <= bullet_hit_d;
      end
   end

   assign Busy           = (state_q == SCAN);
   assign Done           = done_q;
   assign Tank_Hit       = tank_hit_q;
   assign Hit_Bullet_Idx = hit_idx_q;
   assign Bullet_Hit     = bullet_hit_q;

endmodule

// File: tb/tb_tb_collision_scan.sv
// Scoreboard bench for tb_collision_scan: three instances (defaults, owner exclusion, 5 bullets x 3 tanks).
// Expected results are queued when a scan starts and checked by a monitor whenever Done is seen.
// Data buses of the first two instances are shared; each instance has its own Start.
module tb_tb_collision_scan;

   typedef struct {
      int          dc;
      logic [31:0] th;
      logic [31:0] hi;
      logic [31:0] bh;
   } exp_t;

   logic clk, rst_n, start_a, start_b, start_c;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   // Shared stimulus for instances a (SELF_HIT=1) and b (SELF_HIT=0)
   logic [119:0] bx, by;
   logic [11:0]  ba, bo;
   logic [19:0]  tx, ty, ts;
   logic         busy_a, done_a, busy_b, done_b;
   logic [1:0]   th_a, th_b;
   logic [7:0]   hi_a, hi_b;
   logic [11:0]  bh_a, bh_b;

   // Instance c: 5 bullets, 3 tanks
   logic [49:0]  cbx, cby;
   logic [4:0]   cba;
   logic [9:0]   cbo;
   logic [29:0]  ctx, cty, cts;
   logic         busy_c, done_c;
   logic [2:0]   th_c;
   logic [8:0]   hi_c;
   logic [4:0]   bh_c;

   exp_t q_a[$], q_b[$], q_c[$];
   exp_t ea, eb, ec;

   tb_collision_scan u_a (
      .Clk(clk), .Reset_n(rst_n), .Start(start_a),
      .Bullet_X(bx), .Bullet_Y(by), .Bullet_Active(ba), .Bullet_Owner(bo),
      .Tank_X(tx), .Tank_Y(ty), .Tank_Size(ts),
      .Busy(busy_a), .Done(done_a), .Tank_Hit(th_a), .Hit_Bullet_Idx(hi_a), .Bullet_Hit(bh_a));

   tb_collision_scan #(.SELF_HIT(0)) u_b (
      .Clk(clk), .Reset_n(rst_n), .Start(start_b),
      .Bullet_X(bx), .Bullet_Y(by), .Bullet_Active(ba), .Bullet_Owner(bo),
      .Tank_X(tx), .Tank_Y(ty), .Tank_Size(ts),
      .Busy(busy_b), .Done(done_b), .Tank_Hit(th_b), .Hit_Bullet_Idx(hi_b), .Bullet_Hit(bh_b));

   tb_collision_scan #(.NUM_BULLETS(5), .NUM_TANKS(3)) u_c (
      .Clk(clk), .Reset_n(rst_n), .Start(start_c),
      .Bullet_X(cbx), .Bullet_Y(cby), .Bullet_Active(cba), .Bullet_Owner(cbo),
      .Tank_X(ctx), .Tank_Y(cty), .Tank_Size(cts),
      .Busy(busy_c), .Done(done_c), .Tank_Hit(th_c), .Hit_Bullet_Idx(hi_c), .Bullet_Hit(bh_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compare each Done against the oldest queued expectation
   always @(negedge clk) begin
      if (done_a) begin
         if (q_a.size() == 0) begin
            tests++; fails++;
            $display("FAIL a_unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
         end else begin
            ea = q_a.pop_front();
            chk("a_done_cycle", 32'(cyc), 32'(ea.dc));
            chk("a_tank_hit", 32'(th_a), ea.th);
            chk("a_hit_idx", 32'(hi_a), ea.hi);
            chk("a_bullet_hit", 32'(bh_a), ea.bh);
         end
      end
      if (done_b) begin
         if (q_b.size() == 0) begin
            tests++; fails++;
            $display("FAIL b_unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
         end else begin
            eb = q_b.pop_front();
            chk("b_done_cycle", 32'(cyc), 32'(eb.dc));
            chk("b_tank_hit", 32'(th_b), eb.th);
            chk("b_hit_idx", 32'(hi_b), eb.hi);
            chk("b_bullet_hit", 32'(bh_b), eb.bh);
         end
      end
      if (done_c) begin
         if (q_c.size() == 0) begin
            tests++; fails++;
            $display("FAIL c_unexpected_done: got Done=1 expected no Done (cycle %0d)", cyc);
         end else begin
            ec = q_c.pop_front();
            chk("c_done_cycle", 32'(cyc), 32'(ec.dc));
            chk("c_tank_hit", 32'(th_c), ec.th);
            chk("c_hit_idx", 32'(hi_c), ec.hi);
            chk("c_bullet_hit", 32'(bh_c), ec.bh);
         end
      end
   end

   task automatic clr();
      bx = '0; by = '0; ba = '0; bo = '0;
      tx = '0; ty = '0; ts = '0;
   endtask

   task automatic set_b(input int i, input int x, input int y, input bit act, input bit own);
      bx[i*10 +: 10] = 10'(x);
      by[i*10 +: 10] = 10'(y);
      ba[i]          = act;
      bo[i]          = own;
   endtask

   task automatic set_t(input int t, input int x, input int y, input int s);
      tx[t*10 +: 10] = 10'(x);
      ty[t*10 +: 10] = 10'(y);
      ts[t*10 +: 10] = 10'(s);
   endtask

   task automatic clr_c();
      cbx = '0; cby = '0; cba = '0; cbo = '0;
      ctx = '0; cty = '0; cts = '0;
   endtask

   task automatic set_cb(input int i, input int x, input int y, input bit act, input int own);
      cbx[i*10 +: 10] = 10'(x);
      cby[i*10 +: 10] = 10'(y);
      cba[i]          = act;
      cbo[i*2 +: 2]   = 2'(own);
   endtask

   task automatic set_ct(input int t, input int x, input int y, input int s);
      ctx[t*10 +: 10] = 10'(x);
      cty[t*10 +: 10] = 10'(y);
      cts[t*10 +: 10] = 10'(s);
   endtask

   // Pulse Start for one edge (E0); returns the cycle count just after E0
   task automatic go(input bit a, input bit b, input bit c, output int e0);
      start_a = a; start_b = b; start_c = c;
      @(posedge clk); #1;
      e0 = cyc;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
   endtask

   task automatic push(input int which, input int dc, input logic [31:0] th,
                       input logic [31:0] hi, input logic [31:0] bh);
      exp_t e;
      e.dc = dc; e.th = th; e.hi = hi; e.bh = bh;
      if (which == 0) q_a.push_back(e);
      else if (which == 1) q_b.push_back(e);
      else q_c.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int e0, e1;
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      clr(); clr_c();
      idle(3);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_tank_hit", 32'(th_a), 0);
      chk("rst_hit_idx", 32'(hi_a), 0);
      chk("rst_bullet_hit", 32'(bh_a), 0);
      rst_n = 1'b1;
      idle(2);

      // Basic hit on the inclusive corner of tank0
      clr();
      set_t(0, 100, 100, 8); set_t(1, 500, 500, 8);
      set_b(3, 108, 92, 1, 0);
      go(1, 0, 0, e0);
      chk("t1_busy", 32'(busy_a), 1);
      push(0, e0 + 12, 32'h1, 32'h03, 32'h008);
      idle(14);

      // One past the edge, and an inactive bullet dead centre
      clr();
      set_t(0, 100, 100, 8); set_t(1, 500, 500, 8);
      set_b(3, 109, 100, 1, 0);
      set_b(5, 100, 100, 0, 0);
      go(1, 0, 0, e0);
      chk("t2_results_cleared", 32'(bh_a), 0);
      push(0, e0 + 12, 32'h0, 32'h00, 32'h000);
      idle(14);

      // Low bound clamps to 0; high bound past 1023 is not wrapped
      clr();
      set_t(0, 4, 4, 8); set_t(1, 1020, 500, 8);
      set_b(0, 0, 0, 1, 0);
      set_b(1, 1023, 500, 1, 0);
      go(1, 0, 0, e0);
      push(0, e0 + 12, 32'h3, 32'h10, 32'h003);
      idle(14);

      // Owner exclusion (b) versus self-hit allowed (a) on identical data
      clr();
      set_t(0, 100, 100, 8); set_t(1, 500, 500, 8);
      set_b(2, 100, 100, 1, 0);
      set_b(7, 101, 99, 1, 1);
      go(1, 1, 0, e0);
      push(0, e0 + 12, 32'h1, 32'h02, 32'h084);
      push(1, e0 + 12, 32'h1, 32'h07, 32'h080);
      idle(14);

      // Overlapping tanks, ignored mid-scan Start, back-to-back Start in the Done cycle
      clr();
      set_t(0, 200, 200, 10); set_t(1, 205, 205, 10);
      set_b(4, 203, 203, 1, 0);
      set_b(9, 207, 198, 1, 0);
      go(1, 0, 0, e0);
      push(0, e0 + 12, 32'h3, 32'h44, 32'h210);
      idle(2);
      start_a = 1'b1;
      set_b(4, 900, 900, 1, 0);
      @(posedge clk); #1;
      start_a = 1'b0;
      chk("t5_busy_mid", 32'(busy_a), 1);
      idle(9);
      chk("t5_done_cycle", 32'(done_a), 1);
      clr();
      set_t(0, 200, 200, 10); set_t(1, 205, 205, 10);
      set_b(0, 200, 200, 1, 0);
      go(1, 0, 0, e1);
      chk("t5_b2b_busy", 32'(busy_a), 1);
      chk("t5_b2b_tank_clr", 32'(th_a), 0);
      chk("t5_b2b_bullet_clr", 32'(bh_a), 0);
      push(0, e1 + 12, 32'h3, 32'h00, 32'h001);
      idle(14);

      // 5 bullets x 3 tanks: reset mid-scan aborts, then a clean scan
      clr_c();
      set_ct(0, 100, 100, 8); set_ct(1, 500, 500, 5); set_ct(2, 110, 100, 3);
      set_cb(0, 100, 100, 1, 0);
      set_cb(3, 107, 100, 1, 3);
      go(0, 0, 1, e0);
      idle(2);
      chk("t6_partial_hit", 32'(th_c), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy_c), 0);
      chk("t6_rst_done", 32'(done_c), 0);
      chk("t6_rst_tank_hit", 32'(th_c), 0);
      chk("t6_rst_hit_idx", 32'(hi_c), 0);
      chk("t6_rst_bullet_hit", 32'(bh_c), 0);
      idle(2);
      rst_n = 1'b1;
      idle(8);
      go(0, 0, 1, e0);
      push(2, e0 + 5, 32'h5, 32'h0C0, 32'h09);
      idle(8);

      chk("end_queue_a", 32'(q_a.size()), 0);
      chk("end_queue_b", 32'(q_b.size()), 0);
      chk("end_queue_c", 32'(q_c.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
